// File: rtl/sb_tx_payload_packer.sv
// rtl/sb_tx_payload_packer.sv - sideband payload encoder feeding a small FIFO toward the packet framer
// Optional build macro SB_ENC_PARITY_EN adds per-entry even parity output o_dp.
module sb_tx_payload_packer #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_msg_valid,
    input  logic                     i_data_valid,
    input  logic [1:0]               i_mode,
    input  logic [DATA_W-1:0]        i_data_bus,
    input  logic                     i_ack,
    input  logic                     i_clr_err,
    output logic                     o_ready,
    output logic                     o_d_valid,
    output logic [63:0]              o_data_encoded,
    output logic [$clog2(DEPTH):0]   o_level,
`ifdef SB_ENC_PARITY_EN
    output logic                     o_dp,
`endif
    output logic                     o_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
`ifdef SB_ENC_PARITY_EN
    localparam int EW = 65;
`else
    localparam int EW = 64;
`endif

    logic [63:0]   enc;
    logic [EW-1:0] entry;
    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          overflow;

    always_comb begin
        enc = '0;
        if (i_data_valid) begin
            case (i_mode)
                2'd1: enc[63:53] = i_data_bus[10:0];
                2'd2: enc[63 -: DATA_W] = i_data_bus;
                2'd3: begin
                    enc[59]    = i_data_bus[4];
                    enc[58:43] = '1;
                    enc[11]    = i_data_bus[3];
                    enc[7:6]   = i_data_bus[2:1];
                    enc[0]     = i_data_bus[0];
                end
                default: enc = '0;
            endcase
        end
    end

`ifdef SB_ENC_PARITY_EN
    assign entry = {^enc, enc};
`else
    assign entry = enc;
`endif

    assign full  = (count == LW'(DEPTH));
    assign empty = (count == '0);
    // A pop never frees a slot for a same-cycle push: readiness depends only on the registered count.
    assign push  = i_msg_valid && !full;
    assign pop   = i_ack && !empty;

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= entry;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A fresh drop wins over a clear in the same cycle.
            if (i_msg_valid && full) begin
                overflow <= 1'b1;
            end else if (i_clr_err) begin
                overflow <= 1'b0;
            end
        end
    end

    assign head           = mem[rd_ptr];
    assign o_ready        = !full;
    assign o_d_valid      = !empty;
    assign o_data_encoded = empty ? 64'd0 : head[63:0];
    assign o_level        = count;
    assign o_overflow     = overflow;
`ifdef SB_ENC_PARITY_EN
    assign o_dp           = !empty && head[64];
`endif

endmodule

// File: doc/sb_tx_payload_packer.md
SB_TX_PAYLOAD_PACKER -- requirements
Module: sb_tx_payload_packer

Interface
REQ-001 SHALL provide parameter DATA_W, default 16, meaning input data bus width, legal range 11..64.
REQ-002 SHALL provide parameter DEPTH, default 4, meaning payload queue entries, power of two, at least 2.
REQ-003 SHALL provide i_clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL provide i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide i_msg_valid  input  1  a sideband message requests a payload this cycle.
REQ-006 SHALL provide i_data_valid  input  1  the message carries data; when low, the payload is all-zero.
REQ-007 SHALL provide i_mode  input  2  layout select: 0 NODATA, 1 PARAM, 2 WIDE, 3 TESTCFG.
REQ-008 SHALL provide i_data_bus  input  DATA_W  raw message data.
REQ-009 SHALL provide i_ack  input  1  packet framer consumes the head payload.
REQ-010 SHALL provide i_clr_err  input  1  clears the sticky overflow flag.
REQ-011 SHALL provide o_ready  output  1  the queue can accept a message (queue not full).
REQ-012 SHALL provide o_d_valid  output  1  the head payload is valid (queue not empty).
REQ-013 SHALL provide o_data_encoded  output  64  head payload.
REQ-014 SHALL provide o_level  output  log2(DEPTH)+1  current entry count.
REQ-015 SHALL provide o_overflow  output  1  sticky flag: a message was dropped.

Function
REQ-016 SHALL accept (push) when i_msg_valid and o_ready; encoding is combinational from the inputs sampled that cycle.
REQ-017 SHALL encode as all-zero when i_data_valid=0 or i_mode=0.
REQ-018 SHALL encode PARAM as [63:53]=i_data_bus[10:0], rest 0.
REQ-019 SHALL encode WIDE as [63:64-DATA_W]=i_data_bus, rest 0.
REQ-020 SHALL encode TESTCFG as [59]=d[4], [58:43]=all ones, [11]=d[3], [7:6]=d[2:1], [0]=d[0], all other bits 0.
REQ-021 SHALL pop the head when o_d_valid and i_ack; i_ack while empty is ignored.
REQ-022 SHALL present a payload pushed into an empty queue on o_d_valid/o_data_encoded exactly 1 cycle after acceptance.
REQ-023 SHALL hold o_data_encoded stable while o_d_valid=1 and i_ack=0, and drive it to 0 while o_d_valid=0.
REQ-024 SHALL deliver payloads in strict FIFO order; read and write pointers wrap modulo DEPTH.
REQ-025 SHALL perform push and pop in the same cycle when not full: o_level unchanged, both pointers advance.
REQ-026 SHALL keep o_ready=0 when full even if i_ack=1 in that cycle; no same-cycle push-at-full.
REQ-027 SHALL drop i_msg_valid while full and set o_overflow on the next edge; queue contents and pointers remain unaffected.
REQ-028 SHALL clear o_overflow with i_clr_err; a simultaneous new drop takes priority and keeps it set.

Reset
REQ-029 SHALL, on i_rst_n low, clear pointers, o_level, o_d_valid, o_data_encoded and o_overflow to 0 and drive o_ready to 1.
REQ-030 SHALL discard all queued payloads when reset asserts mid-operation; no partial pop or push completes.

Configuration
REQ-031 SHALL, with SB_ENC_PARITY_EN defined, add output o_dp (1 bit, reset 0), the even parity (XOR) of the head payload; it is stored per entry at push and follows REQ-023.
REQ-032 SHALL, without SB_ENC_PARITY_EN, omit o_dp and keep queue entries 64 bits wide.

Verification
REQ-033 SHALL cover: PARAM push, data 0x07FF, empty queue -> next cycle o_d_valid=1, payload 0xFFE0_0000_0000_0000.
REQ-034 SHALL cover: TESTCFG push, data 0x001F, i_ack=1 -> payload 0x0FFF_F800_0000_08C1, o_level returns to 0.
REQ-035 SHALL cover: push 5 WIDE messages (DEPTH=4), no ack -> o_ready=0 after the 4th, o_overflow=1, then 4 acks return the first 4 in order.
REQ-036 SHALL cover: i_msg_valid with i_data_valid=0, mode 2 -> zero payload queued with o_d_valid=1; with SB_ENC_PARITY_EN, o_dp=0.
REQ-037 SHALL cover: queue at level 2, reset pulsed -> o_d_valid=0, o_level=0, o_ready=1, and the next push is seen 1 cycle later.
